// File: rtl/network_driver.sv
// Purpose : initiator for the binary-network classification handshake; takes one
//           pixel vector, pulses start to the runner, times the run, returns the class.
// Latency : accept on edge N -> start in cycle N+1 -> result valid at N+T+2 (timeout)
//           or N+k+3 (early positive seen at run count k).
// Backpressure: in_ready only in IDLE; the result is held in DONE until res_ready.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   in_pixels/in_valid/in_ready   host-side vector handshake
//   pixels, start     stable pixel vector and one-cycle start pulse to the runner
//   neuron_out        runner decision: 00 undecided, 01 positive, 10 negative
//   res_class/res_cycles/res_valid/res_ready   result handshake
//   busy              high in every state except IDLE
module network_driver #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 7,
  parameter int GUARD      = 4,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int RUN_CYCLES = HEIGHT * (2 ** (WIDTH + 2)),
  localparam int T          = RUN_CYCLES + GUARD,
  localparam int CW         = $clog2(T + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HEIGHT-1:0] in_pixels,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HEIGHT-1:0] pixels,
  output logic              start,
  input  logic [1:0]        neuron_out,
  output logic [1:0]        res_class,
  output logic [CW-1:0]     res_cycles,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_POS  = 2'b01;
  localparam logic [1:0] CLS_NEG  = 2'b10;
  localparam logic [1:0] CLS_FLT  = 2'b11;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [HEIGHT-1:0]   pixels_q;
  logic                start_q;
  logic                in_ready_q;
  logic                res_valid_q;
  logic [1:0]          res_class_q;
  logic [CW-1:0]       res_cycles_q;
  logic                busy_q;

  // Shared counter helpers for DRAIN and RUN.
  logic [CW-1:0]       cnt_inc_d;
  logic                cnt_last_d;
  logic                settled_d;
  logic                early_hit_d;
  logic [1:0]          timeout_class_d;

  assign cnt_inc_d   = cnt_q + CW'(1);
  assign cnt_last_d  = (cnt_q == CW'(T - 1));
  // The runner resets its network during the first two run cycles, so its
  // output is meaningless until then.
  assign settled_d   = (cnt_q >= CW'(2));
  assign early_hit_d = EARLY_EXIT && settled_d && (neuron_out == CLS_POS);

  // Anything other than a clean positive/negative at timeout is a fault.
  always_comb begin
    timeout_class_d = CLS_FLT;
    case (neuron_out)
      2'b01:   timeout_class_d = CLS_POS;
      2'b10:   timeout_class_d = CLS_NEG;
      default: timeout_class_d = CLS_FLT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DRAIN;
      cnt_q        <= '0;
      pixels_q     <= '0;
      start_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_class_q  <= CLS_NONE;
      res_cycles_q <= '0;
      busy_q       <= 1'b1;
    end else begin
      // start is a pulse: only the IDLE accept raises it, for one cycle.
      start_q <= 1'b0;
      case (state_q)
        // Wait out a full run length so a pass the runner may still be
        // executing (e.g. after a mid-run reset) finishes before a new start.
        S_DRAIN: begin
          if (cnt_last_d) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        S_IDLE: begin
          if (in_valid) begin
            pixels_q   <= in_pixels;
            start_q    <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end

        // The counter stops at T-1 on exit so it never wraps.
        S_RUN: begin
          if (early_hit_d) begin
            res_class_q  <= CLS_POS;
            res_cycles_q <= cnt_inc_d;
            res_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else if (cnt_last_d) begin
            res_class_q  <= timeout_class_d;
            res_cycles_q <= CW'(T);
            res_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        // Going straight to IDLE (not START) leaves a one-cycle bubble, so
        // in_valid seen here is never accepted.
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_DRAIN;
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign pixels     = pixels_q;
  assign start      = start_q;
  assign res_class  = res_class_q;
  assign res_cycles = res_cycles_q;
  assign res_valid  = res_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_network_driver.sv
// Purpose : directed bench for network_driver with a stub runner driven from the bench.
// Latency : checks reset drain length, early-exit and timeout result timing.
// Backpressure: holds res_ready low in DONE and checks the result is held.
module tb_network_driver;

  localparam int T  = 7172;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    in_pixels;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    pixels;
  logic          start;
  logic [1:0]    neuron_out;
  logic [1:0]    res_class;
  logic [CW-1:0] res_cycles;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  network_driver dut (
    .clk        (clk),
    .rst        (rst),
    .in_pixels  (in_pixels),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixels     (pixels),
    .start      (start),
    .neuron_out (neuron_out),
    .res_class  (res_class),
    .res_cycles (res_cycles),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance past a rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count cycles with in_ready low (starting with the current one); also
  // count any start/res_valid seen while draining.
  task automatic drain_count(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (!in_ready && n < T + 10) begin
      if (start || res_valid) bad++;
      n++;
      tick();
    end
  endtask

  // Stub runner: value a for cnt<2, b for cnt<sw, c afterwards.
  function automatic logic [1:0] stub(input int k, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c,
                                      input int sw);
    if (k < 2)       return a;
    else if (k < sw) return b;
    else             return c;
  endfunction

  // Present a vector in IDLE and run it to DONE; checks the pulse, pixels and
  // the result against hand-computed values.
  task automatic do_run(input string tag, input logic [6:0] pix,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input int sw, input logic [1:0] exp_cls, input int exp_cyc,
                        input int exp_lat);
    int lat;
    int npulse;
    int pix_bad;
    in_pixels = pix;
    in_valid  = 1'b1;
    tick();                       // edge N: accepted
    in_valid  = 1'b0;
    in_pixels = 7'h00;
    lat       = 1;
    chk({tag, "_start"}, start, 1);
    chk({tag, "_inrdy_lo"}, in_ready, 0);
    chk({tag, "_pixels"}, pixels, pix);
    npulse  = 1;
    pix_bad = 0;
    while (!res_valid && lat < T + 10) begin
      if (lat >= 2) neuron_out = stub(lat - 2, a, b, c, sw);
      tick();
      lat++;
      if (start) npulse++;
      if (pixels !== pix) pix_bad++;
    end
    neuron_out = 2'b00;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_pix_stable"}, pix_bad, 0);
    chk({tag, "_class"}, res_class, exp_cls);
    chk({tag, "_cycles"}, res_cycles, exp_cyc);
    chk({tag, "_done_inrdy"}, in_ready, 0);
    chk({tag, "_done_busy"}, busy, 1);
  endtask

  task automatic release_res(input string tag, input logic [1:0] exp_cls);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_rel_vld"}, res_valid, 0);
    chk({tag, "_rel_inrdy"}, in_ready, 1);
    chk({tag, "_rel_busy"}, busy, 0);
    chk({tag, "_rel_class_held"}, res_class, exp_cls);
  endtask

  initial begin
    int n;
    int bad;
    logic [6:0] held_pix;

    rst        = 1'b1;
    in_valid   = 1'b1;
    in_pixels  = 7'h55;
    res_ready  = 1'b0;
    neuron_out = 2'b00;

    // ---- Reset drain with in_valid held high ----
    tick();
    rst = 1'b0;
    chk("rst_pixels", pixels, 0);
    chk("rst_start", start, 0);
    chk("rst_inrdy", in_ready, 0);
    chk("rst_resvld", res_valid, 0);
    chk("rst_class", res_class, 0);
    chk("rst_cycles", res_cycles, 0);
    chk("rst_busy", busy, 1);
    drain_count(n, bad);
    in_valid = 1'b0;
    chk("drain_len", n, T);
    chk("drain_quiet", bad, 0);
    chk("drain_busy_lo", busy, 0);
    tick();
    chk("idle_hold_inrdy", in_ready, 1);
    chk("idle_no_start", start, 0);

    // ---- Positive early exit at cnt=500 ----
    do_run("pos", 7'h7F, 2'b00, 2'b00, 2'b01, 500, 2'b01, 501, 503);
    release_res("pos", 2'b01);

    // ---- Negative by timeout ----
    do_run("neg", 7'h2C, 2'b00, 2'b00, 2'b10, 7168, 2'b10, T, T + 2);
    release_res("neg", 2'b10);

    // ---- Settle mask: 01 only at cnt 0,1 then 00 -> fault ----
    do_run("mask", 7'h01, 2'b01, 2'b00, 2'b00, T, 2'b11, T, T + 2);
    release_res("mask", 2'b11);

    // ---- 11 at timeout -> fault ----
    do_run("f11", 7'h40, 2'b01, 2'b00, 2'b11, 7168, 2'b11, T, T + 2);
    release_res("f11", 2'b11);

    // ---- Backpressure in DONE ----
    do_run("bp", 7'h5A, 2'b00, 2'b00, 2'b01, 30, 2'b01, 31, 33);
    held_pix = 7'h5A;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_pixels = 7'h33;
      tick();
      if (res_valid !== 1'b1 || res_class !== 2'b01 || pixels !== held_pix ||
          in_ready !== 1'b0 || start !== 1'b0) bad++;
    end
    chk("bp_hold", bad, 0);
    // in_valid high on the release edge must not be accepted.
    in_valid  = 1'b1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_rel_inrdy", in_ready, 1);
    chk("bp_rel_vld", res_valid, 0);
    chk("bp_bubble_no_start", start, 0);
    chk("bp_bubble_pixels", pixels, held_pix);
    in_valid = 1'b0;
    tick();
    chk("bp_idle_stay", in_ready, 1);

    // ---- Reset mid-run at cnt=100 ----
    in_pixels = 7'h2A;
    in_valid  = 1'b1;
    tick();                       // edge N
    in_valid  = 1'b0;
    for (int i = 0; i < 101; i++) tick();   // now in cycle N+102, cnt=100
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_start", start, 0);
    chk("mid_resvld", res_valid, 0);
    chk("mid_inrdy", in_ready, 0);
    chk("mid_busy", busy, 1);
    chk("mid_class_clr", res_class, 0);
    drain_count(n, bad);
    chk("mid_drain_len", n, T);
    chk("mid_drain_quiet", bad, 0);
    do_run("post", 7'h13, 2'b00, 2'b00, 2'b01, 10, 2'b01, 11, 13);
    release_res("post", 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
